// File: rtl/dp_ram_arbiter_if.sv
// Requester, response and RAM-port bundle for dp_ram_arbiter.
// slave = arbiter side, master = requesters + RAM side.
interface dp_ram_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;

  logic                  rsp_valid_a, rsp_valid_b;
  logic [ID_WIDTH-1:0]   rsp_id_a,    rsp_id_b;
  logic [DATA_WIDTH-1:0] rsp_data_a,  rsp_data_b;

  logic [ADDR_WIDTH-1:0] ram_addr_a, ram_addr_b;
  logic [DATA_WIDTH-1:0] ram_data_a, ram_data_b;
  logic                  ram_we_a,   ram_we_b;
  logic [DATA_WIDTH-1:0] ram_q_a,    ram_q_b;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_q_a, ram_q_b,
    output req_ready,
    output rsp_valid_a, rsp_valid_b, rsp_id_a, rsp_id_b, rsp_data_a, rsp_data_b,
    output ram_addr_a, ram_addr_b, ram_data_a, ram_data_b, ram_we_a, ram_we_b
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_q_a, ram_q_b,
    input  req_ready,
    input  rsp_valid_a, rsp_valid_b, rsp_id_a, rsp_id_b, rsp_data_a, rsp_data_b,
    input  ram_addr_a, ram_addr_b, ram_data_a, ram_data_b, ram_we_a, ram_we_b
  );
endinterface

// File: rtl/dp_ram_arbiter.sv
// Round-robin two-port arbiter in front of a dual-port synchronous RAM, with
// per-port read-ID tracking. Optional counters: define DP_ARB_STATS_EN.

// Read-return tracker for one RAM port: {valid, id} delayed RD_LATENCY cycles.
module dp_ram_rd_pipe #(
  parameter int RD_LATENCY = 2,
  parameter int ID_WIDTH   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  input  logic [ID_WIDTH-1:0] in_id,
  output logic                out_vld,
  output logic [ID_WIDTH-1:0] out_id
);
  logic [RD_LATENCY-1:0]               vld_pipe;
  logic [RD_LATENCY-1:0][ID_WIDTH-1:0] id_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      id_pipe[0]  <= in_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  assign out_vld = vld_pipe[RD_LATENCY-1];
  assign out_id  = id_pipe[RD_LATENCY-1];
endmodule

module dp_ram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  dp_ram_arbiter_if.slave bus
`ifdef DP_ARB_STATS_EN
  ,
  output logic [31:0] stat_grants,
  output logic [15:0] stat_hazards
`endif
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;
  logic [NUM_REQ-1:0]                 we_v;

  assign addr_v  = bus.req_addr;
  assign wdata_v = bus.req_wdata;
  assign we_v    = bus.req_we;

  logic [ID_WIDTH-1:0] ptr, ptr_nxt, a_id, b_id, scan_idx;
  logic                a_found, b_found, hazard, grant_a, grant_b;
  int                  scan_sum, nxt_sum;

  // First two valid requesters in rotation order starting at ptr.
  always_comb begin
    a_found  = 1'b0;
    b_found  = 1'b0;
    a_id     = '0;
    b_id     = '0;
    scan_sum = 0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = int'(ptr) + k;
      if (scan_sum >= NUM_REQ) scan_sum = scan_sum - NUM_REQ;
      scan_idx = ID_WIDTH'(scan_sum);
      if (bus.req_valid[scan_idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_id    = scan_idx;
        end else if (!b_found) begin
          b_found = 1'b1;
          b_id    = scan_idx;
        end
      end
    end
  end

  // B is deferred (not replaced) when it collides with A and either side writes.
  assign hazard  = a_found && b_found && (addr_v[a_id] == addr_v[b_id]) &&
                   (we_v[a_id] || we_v[b_id]);
  assign grant_a = a_found && !rst;
  assign grant_b = b_found && !hazard && !rst;

  always_comb begin
    bus.req_ready = '0;
    if (grant_a) bus.req_ready[a_id] = 1'b1;
    if (grant_b) bus.req_ready[b_id] = 1'b1;
    bus.ram_addr_a = grant_a ? addr_v[a_id]  : '0;
    bus.ram_data_a = grant_a ? wdata_v[a_id] : '0;
    bus.ram_we_a   = grant_a && we_v[a_id];
    bus.ram_addr_b = grant_b ? addr_v[b_id]  : '0;
    bus.ram_data_b = grant_b ? wdata_v[b_id] : '0;
    bus.ram_we_b   = grant_b && we_v[b_id];
  end

  always_comb begin
    nxt_sum = grant_b ? int'(b_id) + 1 : int'(a_id) + 1;
    if (nxt_sum >= NUM_REQ) nxt_sum = 0;
    ptr_nxt = ID_WIDTH'(nxt_sum);
  end

  always_ff @(posedge clk) begin
    if (rst)          ptr <= '0;
    else if (grant_a) ptr <= ptr_nxt;
  end

  logic [1:0]               rd_issue, rsp_vld;
  logic [1:0][ID_WIDTH-1:0] rd_id, rsp_id;

  assign rd_issue[0] = grant_a && !we_v[a_id];
  assign rd_issue[1] = grant_b && !we_v[b_id];
  assign rd_id[0]    = a_id;
  assign rd_id[1]    = b_id;

  for (genvar p = 0; p < 2; p++) begin : g_port
    dp_ram_rd_pipe #(.RD_LATENCY(RD_LATENCY), .ID_WIDTH(ID_WIDTH)) u_pipe (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (rd_issue[p]),
      .in_id   (rd_id[p]),
      .out_vld (rsp_vld[p]),
      .out_id  (rsp_id[p])
    );
  end

  assign bus.rsp_valid_a = rsp_vld[0];
  assign bus.rsp_id_a    = rsp_id[0];
  assign bus.rsp_data_a  = bus.ram_q_a;
  assign bus.rsp_valid_b = rsp_vld[1];
  assign bus.rsp_id_b    = rsp_id[1];
  assign bus.rsp_data_b  = bus.ram_q_b;

`ifdef DP_ARB_STATS_EN
  logic [1:0]  n_grants;
  logic [32:0] grants_sum;
  logic        hazard_evt;

  assign n_grants   = {1'b0, grant_a} + {1'b0, grant_b};
  assign grants_sum = {1'b0, stat_grants} + 33'(n_grants);
  assign hazard_evt = grant_a && hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants  <= '0;
      stat_hazards <= '0;
    end else begin
      stat_grants <= grants_sum[32] ? '1 : grants_sum[31:0];
      if (hazard_evt && !(&stat_hazards)) stat_hazards <= stat_hazards + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Bench for dp_ram_arbiter: directed scenarios plus a randomized run against
// a queue-based round-robin model with a shadow memory and timed expectations.
module tb_dp_ram_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int RL = 2;
  localparam int IW = 2;
  localparam int RCYC = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dp_ram_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef DP_ARB_STATS_EN
  logic [31:0] stat_grants;
  logic [15:0] stat_hazards;
`endif

  dp_ram_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DP_ARB_STATS_EN
    ,
    .stat_grants  (stat_grants),
    .stat_hazards (stat_hazards)
`endif
  );

  // Dual-port RAM, 2-cycle registered read, write-first per port; mem[i]=i on reset.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] qa1, qb1, qa, qb;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= DW'(i);
    end else begin
      if (bus.ram_we_a) mem[bus.ram_addr_a] <= bus.ram_data_a;
      if (bus.ram_we_b) mem[bus.ram_addr_b] <= bus.ram_data_b;
    end
    qa1 <= bus.ram_we_a ? bus.ram_data_a : mem[bus.ram_addr_a];
    qb1 <= bus.ram_we_b ? bus.ram_data_b : mem[bus.ram_addr_b];
    qa  <= qa1;
    qb  <= qb1;
  end
  assign bus.ram_q_a = qa;
  assign bus.ram_q_b = qb;

  task automatic idle();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]         = 1'b1;
    bus.req_we[i]            = we;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i), 16'hAAAA);
      @(negedge clk);
      checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL reset.ready c=%0d got=%b exp=0", c, bus.req_ready); end
      checks++; if ({bus.ram_we_a, bus.ram_we_b} !== 2'b00) begin failures++; $display("FAIL reset.we c=%0d got=%b exp=00", c, {bus.ram_we_a, bus.ram_we_b}); end
      checks++; if ({bus.rsp_valid_a, bus.rsp_valid_b} !== 2'b00) begin failures++; $display("FAIL reset.rsp_valid c=%0d got=%b exp=00", c, {bus.rsp_valid_a, bus.rsp_valid_b}); end
      checks++; if ({bus.rsp_id_a, bus.rsp_id_b} !== '0) begin failures++; $display("FAIL reset.rsp_id c=%0d got=%h exp=0", c, {bus.rsp_id_a, bus.rsp_id_b}); end
      next_cycle();
    end
    idle();
    rst = 1'b0;
  endtask

  task automatic test_two_reads();
    do_reset();
    set_req(1, 1'b0, 8'h10, '0);
    set_req(2, 1'b0, 8'h20, '0);
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0110) begin failures++; $display("FAIL two_reads.ready got=%b exp=0110", bus.req_ready); end
    checks++; if ({bus.ram_addr_a, bus.ram_addr_b} !== 16'h1020) begin failures++; $display("FAIL two_reads.addr got=%h exp=1020", {bus.ram_addr_a, bus.ram_addr_b}); end
    checks++; if ({bus.ram_we_a, bus.ram_we_b} !== 2'b00) begin failures++; $display("FAIL two_reads.we got=%b exp=00", {bus.ram_we_a, bus.ram_we_b}); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if ({bus.rsp_valid_a, bus.rsp_valid_b} !== 2'b00) begin failures++; $display("FAIL two_reads.early_rsp got=%b exp=00", {bus.rsp_valid_a, bus.rsp_valid_b}); end
    next_cycle();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(8'h30 + i), '0);
    @(negedge clk);
    checks++; if ({bus.rsp_valid_a, bus.rsp_id_a, bus.rsp_data_a} !== {1'b1, 2'd1, 16'h0010}) begin failures++; $display("FAIL two_reads.rsp_a got=%b/%0d/%h exp=1/1/0010", bus.rsp_valid_a, bus.rsp_id_a, bus.rsp_data_a); end
    checks++; if ({bus.rsp_valid_b, bus.rsp_id_b, bus.rsp_data_b} !== {1'b1, 2'd2, 16'h0020}) begin failures++; $display("FAIL two_reads.rsp_b got=%b/%0d/%h exp=1/2/0020", bus.rsp_valid_b, bus.rsp_id_b, bus.rsp_data_b); end
    // pointer now 3: rotation continues with requester 3 then 0
    checks++; if (bus.req_ready !== 4'b1001) begin failures++; $display("FAIL two_reads.ptr_ready got=%b exp=1001", bus.req_ready); end
    checks++; if ({bus.ram_addr_a, bus.ram_addr_b} !== 16'h3330) begin failures++; $display("FAIL two_reads.ptr_addr got=%h exp=3330", {bus.ram_addr_a, bus.ram_addr_b}); end
    next_cycle();
    idle();
  endtask

  task automatic test_hazard();
    do_reset();
    set_req(0, 1'b1, 8'h05, 16'h0055);
    set_req(1, 1'b0, 8'h05, '0);
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL hazard.ready got=%b exp=0001", bus.req_ready); end
    checks++; if ({bus.ram_we_a, bus.ram_addr_a, bus.ram_data_a} !== {1'b1, 8'h05, 16'h0055}) begin failures++; $display("FAIL hazard.port_a got=%b/%h/%h exp=1/05/0055", bus.ram_we_a, bus.ram_addr_a, bus.ram_data_a); end
    checks++; if ({bus.ram_we_b, bus.ram_addr_b, bus.ram_data_b} !== '0) begin failures++; $display("FAIL hazard.port_b_idle got=%b/%h/%h exp=0/00/0000", bus.ram_we_b, bus.ram_addr_b, bus.ram_data_b); end
    next_cycle();
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL hazard.retry_ready got=%b exp=0010", bus.req_ready); end
    checks++; if ({bus.ram_we_a, bus.ram_addr_a} !== {1'b0, 8'h05}) begin failures++; $display("FAIL hazard.retry_port_a got=%b/%h exp=0/05", bus.ram_we_a, bus.ram_addr_a); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if ({bus.rsp_valid_a, bus.rsp_valid_b} !== 2'b00) begin failures++; $display("FAIL hazard.write_no_rsp got=%b exp=00", {bus.rsp_valid_a, bus.rsp_valid_b}); end
    next_cycle();
    @(negedge clk);
    checks++; if ({bus.rsp_valid_a, bus.rsp_id_a, bus.rsp_data_a} !== {1'b1, 2'd1, 16'h0055}) begin failures++; $display("FAIL hazard.rsp got=%b/%0d/%h exp=1/1/0055", bus.rsp_valid_a, bus.rsp_id_a, bus.rsp_data_a); end
    // two reads of one address are not a hazard
    set_req(2, 1'b0, 8'h05, '0);
    set_req(3, 1'b0, 8'h05, '0);
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b1100) begin failures++; $display("FAIL hazard.read_read got=%b exp=1100", bus.req_ready); end
    next_cycle();
    idle();
  endtask

  task automatic test_fairness();
    int cnt [N];
    logic [N-1:0] exp;
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(8'h40 + i), '0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      checks++; if (bus.req_ready !== exp) begin failures++; $display("FAIL fairness.ready c=%0d got=%b exp=%b", c, bus.req_ready, exp); end
      for (int i = 0; i < N; i++) if (bus.req_ready[i] === 1'b1) cnt[i]++;
      next_cycle();
    end
    idle();
    for (int i = 0; i < N; i++) begin
      checks++; if (cnt[i] != 4) begin failures++; $display("FAIL fairness.count req=%0d got=%0d exp=4", i, cnt[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1'b0, 8'h10, '0);
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL reset_mid.ready got=%b exp=0001", bus.req_ready); end
    next_cycle();
    rst = 1'b1;
    idle();
    set_req(1, 1'b0, 8'h11, '0);
    @(negedge clk);
    checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL reset_mid.ready_in_rst got=%b exp=0000", bus.req_ready); end
    next_cycle();
    rst = 1'b0;
    idle();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), '0);
    @(negedge clk);
    checks++; if ({bus.rsp_valid_a, bus.rsp_valid_b} !== 2'b00) begin failures++; $display("FAIL reset_mid.rsp got=%b exp=00", {bus.rsp_valid_a, bus.rsp_valid_b}); end
    checks++; if (bus.req_ready !== 4'b0011) begin failures++; $display("FAIL reset_mid.ptr got=%b exp=0011", bus.req_ready); end
    next_cycle();
    idle();
  endtask

  task automatic test_random();
    logic          pv [N];
    logic          pwe [N];
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];
    logic [DW-1:0] shadow [0:255];
    logic          exp_rv [2][0:RCYC+RL];
    logic [IW-1:0] exp_id [2][0:RCYC+RL];
    logic [DW-1:0] exp_d  [2][0:RCYC+RL];
    int order[$];
    int mp, a, b;
    logic ga, gb;
    logic [N-1:0] exp_ready;
    do_reset();
    mp = 0;
    for (int i = 0; i < 256; i++) shadow[i] = DW'(i);
    for (int p = 0; p < 2; p++) for (int c = 0; c <= RCYC + RL; c++) begin
      exp_rv[p][c] = 1'b0; exp_id[p][c] = '0; exp_d[p][c] = '0;
    end
    for (int i = 0; i < N; i++) begin pv[i] = 1'b0; pwe[i] = 1'b0; pa[i] = '0; pd[i] = '0; end
    for (int cyc = 0; cyc < RCYC; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (pv[i]) begin
          if ($urandom_range(0, 15) == 0) pv[i] = 1'b0;
        end else if ($urandom_range(0, 3) != 0) begin
          pv[i] = 1'b1; pwe[i] = 1'($urandom_range(0, 1));
          pa[i] = AW'($urandom_range(0, 7)); pd[i] = DW'($urandom);
        end
      end
      idle();
      for (int i = 0; i < N; i++) if (pv[i]) set_req(i, pwe[i], pa[i], pd[i]);
      // model: valid requesters listed in rotation order from the model pointer
      order.delete();
      for (int k = 0; k < N; k++) if (pv[(mp + k) % N]) order.push_back((mp + k) % N);
      ga = order.size() > 0;
      a = ga ? order[0] : 0;
      b = (order.size() > 1) ? order[1] : 0;
      gb = (order.size() > 1) && !((pa[a] == pa[b]) && (pwe[a] || pwe[b]));
      exp_ready = '0;
      if (ga) exp_ready[a] = 1'b1;
      if (gb) exp_ready[b] = 1'b1;
      @(negedge clk);
      checks++; if (bus.req_ready !== exp_ready) begin failures++; $display("FAIL random.ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready); end
      checks++;
      if (ga ? ({bus.ram_we_a, bus.ram_addr_a} !== {pwe[a], pa[a]}) || (pwe[a] && bus.ram_data_a !== pd[a])
             : ({bus.ram_we_a, bus.ram_addr_a, bus.ram_data_a} !== '0)) begin
        failures++; $display("FAIL random.port_a cyc=%0d got=%b/%h/%h exp_grant=%b req=%0d", cyc, bus.ram_we_a, bus.ram_addr_a, bus.ram_data_a, ga, a);
      end
      checks++;
      if (gb ? ({bus.ram_we_b, bus.ram_addr_b} !== {pwe[b], pa[b]}) || (pwe[b] && bus.ram_data_b !== pd[b])
             : ({bus.ram_we_b, bus.ram_addr_b, bus.ram_data_b} !== '0)) begin
        failures++; $display("FAIL random.port_b cyc=%0d got=%b/%h/%h exp_grant=%b req=%0d", cyc, bus.ram_we_b, bus.ram_addr_b, bus.ram_data_b, gb, b);
      end
      checks++;
      if (bus.rsp_valid_a !== exp_rv[0][cyc] ||
          (exp_rv[0][cyc] && {bus.rsp_id_a, bus.rsp_data_a} !== {exp_id[0][cyc], exp_d[0][cyc]})) begin
        failures++; $display("FAIL random.rsp_a cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, bus.rsp_valid_a, bus.rsp_id_a, bus.rsp_data_a, exp_rv[0][cyc], exp_id[0][cyc], exp_d[0][cyc]);
      end
      checks++;
      if (bus.rsp_valid_b !== exp_rv[1][cyc] ||
          (exp_rv[1][cyc] && {bus.rsp_id_b, bus.rsp_data_b} !== {exp_id[1][cyc], exp_d[1][cyc]})) begin
        failures++; $display("FAIL random.rsp_b cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, bus.rsp_valid_b, bus.rsp_id_b, bus.rsp_data_b, exp_rv[1][cyc], exp_id[1][cyc], exp_d[1][cyc]);
      end
      // commit: reads see memory before this cycle's writes, response RL cycles later
      if (ga && !pwe[a]) begin exp_rv[0][cyc+RL] = 1'b1; exp_id[0][cyc+RL] = IW'(a); exp_d[0][cyc+RL] = shadow[pa[a]]; end
      if (gb && !pwe[b]) begin exp_rv[1][cyc+RL] = 1'b1; exp_id[1][cyc+RL] = IW'(b); exp_d[1][cyc+RL] = shadow[pa[b]]; end
      if (ga && pwe[a]) shadow[pa[a]] = pd[a];
      if (gb && pwe[b]) shadow[pa[b]] = pd[b];
      if (ga) pv[a] = 1'b0;
      if (gb) pv[b] = 1'b0;
      if (gb) mp = (b + 1) % N;
      else if (ga) mp = (a + 1) % N;
      next_cycle();
    end
    idle();
  endtask

`ifdef DP_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    set_req(0, 1'b1, 8'h05, 16'h0055);
    set_req(1, 1'b0, 8'h05, '0);
    next_cycle();
    bus.req_valid[0] = 1'b0;
    next_cycle();
    idle();
    set_req(1, 1'b0, 8'h10, '0);
    set_req(2, 1'b0, 8'h20, '0);
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (stat_grants !== 32'd4) begin failures++; $display("FAIL stats.grants got=%0d exp=4", stat_grants); end
    checks++; if (stat_hazards !== 16'd1) begin failures++; $display("FAIL stats.hazards got=%0d exp=1", stat_hazards); end
    next_cycle();
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_two_reads();
    test_hazard();
    test_fairness();
    test_reset_mid();
    test_random();
`ifdef DP_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dp_ram_arbiter.md
Name: dp_ram_arbiter

Overview:
Shares one dual-port synchronous RAM (2-cycle registered read, write-first per port) between NUM_REQ requesters. Each cycle it grants up to two requests, one per RAM port, in round-robin order. It blocks same-address hazards between the two ports. It tracks read latency so each read returns with its requester ID. Sits between the convolution-stream address generators and the feature-map RAM.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 8, RAM address width
- RD_LATENCY, 2, RAM read latency in cycles (address to q); must be ≥1
- ID_WIDTH, $clog2(NUM_REQ), requester ID width (localparam)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_ready  out  NUM_REQ  grant this cycle (combinational); transfer = valid & ready
- rsp_valid_a / rsp_valid_b  out  1  read data valid on port A / B
- rsp_id_a / rsp_id_b  out  ID_WIDTH  requester that issued the read
- rsp_data_a / rsp_data_b  out  DATA_WIDTH  read data (equal to ram_q_a / ram_q_b)
- ram_addr_a / ram_addr_b  out  ADDR_WIDTH  RAM port address
- ram_data_a / ram_data_b  out  DATA_WIDTH  RAM port write data
- ram_we_a / ram_we_b  out  1  RAM port write enable
- ram_q_a / ram_q_b  in  DATA_WIDTH  RAM read data

Behaviour:
- Priority pointer ptr (ID_WIDTH bits, reset 0). Requesters are scanned ptr, ptr+1, … modulo NUM_REQ.
- First valid requester in scan order gets port A. The next valid requester gets port B unless a hazard applies.
- Hazard: the B candidate has the same address as the A grant and at least one of the two is a write. The B candidate is then not granted this cycle. No other requester is tried for port B.
- RAM drive is combinational from the grants. An ungranted port drives addr 0, data 0, we 0.
- ptr update on the clock edge: one past the last granted ID (B if granted, else A); unchanged if nothing is granted.
- A requester must hold valid, we, addr and wdata stable until ready. Dropping valid before ready is legal; the request is withdrawn.
- Read tracking: each port has an RD_LATENCY-deep shift register of {valid, id}.
  - Stage 0 is loaded with (granted & ~we, id).
  - rsp_valid_x / rsp_id_x are the last stage.
  - Read response arrives exactly RD_LATENCY cycles after the grant cycle.
  - Writes produce no response.
- Back-to-back grants are allowed every cycle. Throughput is up to 2 transfers/cycle.
- Reset values: ptr = 0, all pipeline stages invalid, so rsp_valid_a/b = 0 and rsp_id_a/b = 0.
- During rst = 1, req_ready = 0 and ram_we_a/b = 0.
- Reset mid-operation: in-flight reads are discarded and no rsp_valid is emitted for them.
- NUM_REQ requesters all valid: the full rotation grants every requester within ceil(NUM_REQ/2) cycles. No starvation.

Optional Feature:
DP_ARB_STATS_EN
- Defined: adds outputs stat_grants (32 bits) and stat_hazards (16 bits).
  - stat_grants increments by the number of grants per cycle (0/1/2).
  - stat_hazards increments once per cycle in which a hazard deferral occurs.
  - Both saturate at all-ones and clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst high 3 cycles, all req_valid = 0 → req_ready = 0, ram_we_a/b = 0, rsp_valid_a/b = 0 throughout.
- Two reads: req 1 reads addr 0x10 and req 2 reads addr 0x20 with RAM preloaded mem[i] = i, in cycle T → both granted at T; at T+2 rsp_valid_a = 1, id 1, data 0x10; rsp_valid_b = 1, id 2, data 0x20; ptr = 3.
- Hazard: req 0 writes 0x55 to addr 0x05 and req 1 reads addr 0x05 → cycle T grants only req 0 (ram_we_a = 1). Req 1 is granted at T+1 and receives data 0x55 at T+3.
- Fairness: all 4 requesters reading continuously for 8 cycles → grant pairs (0,1), (2,3), (0,1), …; each requester gets exactly 4 grants.
- Reset mid-read: read granted at T, rst asserted at T+1 → no rsp_valid at T+2; ptr = 0 after reset.
- Stats (with DP_ARB_STATS_EN): hazard scenario followed by the two-read scenario → stat_grants = 4, stat_hazards = 1.
